uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter for the UART block; the transmit-side counterpart of the UART receiver. It accepts a parallel byte with a valid strobe and serialises it as start bit, DATA_WIDTH data bits LSB first, optional parity bit, and one stop bit. Each bit lasts Prescale system-clock cycles, using the same Prescale convention as the receiver, so a TX/RX pair with equal Prescale and parity settings interoperates. The block sits between the system-side data source and the serial line.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel data to transmit
DATA_VALID  input  1  request to send P_DATA
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  5  clk cycles per serial bit
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  frame in progress, registered
tx_done  output  1  one-cycle pulse at frame end, registered

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, TX_OUT=1, busy=0, tx_done=0, all counters and holding registers cleared. Reset mid-frame aborts the frame; the line returns high on the next edge.
- Accept: at a clk edge where state=IDLE and DATA_VALID=1, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale (effective value = max(Prescale,2)) into holding registers.
- Parity is computed once from the latched data: even = XOR of data bits; odd = inverted XOR.
- Input changes after accept do not affect the frame.
- DATA_VALID while busy=1 is ignored. There is no queue, and no pending request is remembered.
- Latency: on the edge that accepts, the FSM enters START. From that edge TX_OUT=0 and busy=1.
- FSM states:
  - IDLE: TX_OUT=1.
  - START: TX_OUT=0.
  - DATA: TX_OUT = data[bit_idx], with bit_idx from 0 to DATA_WIDTH-1.
  - PARITY: TX_OUT = parity bit.
  - STOP: TX_OUT=1.
- Bit timing: edge counter runs 0..P-1 in every non-IDLE state (P = latched effective Prescale).
  - When the counter reaches P-1 it wraps to 0 and the bit ends.
  - START moves to DATA.
  - DATA increments bit_idx. After bit DATA_WIDTH-1, DATA moves to PARITY if PAR_EN was latched, otherwise to STOP.
  - PARITY moves to STOP.
  - STOP moves to IDLE.
- Every bit is held exactly P cycles. Frame length is (DATA_WIDTH+2)*P cycles, or (DATA_WIDTH+3)*P with parity.
- End of frame: on the edge leaving STOP, busy=0 and tx_done=1 for exactly one cycle. TX_OUT stays 1.
- Back-to-back frames: the earliest next accept is the edge at which busy=0 is first seen, i.e. one cycle after tx_done rises. The stop level therefore lasts at least P+1 cycles between frames.
- TX_OUT output constraints:
  - Registered only, glitch-free.
  - Never X after reset.
  - Changes only on bit boundaries.
- Counter widths: edge counter 5 bits; bit_idx wide enough for DATA_WIDTH-1. No arithmetic overflow is possible since P ≤ 31.

Test Plan:
- Reset: rst=1 for 3 cycles with DATA_VALID=1 -> TX_OUT=1, busy=0, tx_done=0 throughout; no frame starts.
- No parity: Prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID.
  - TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles.
  - busy high 80 cycles.
  - tx_done pulses once on the 80th edge after accept.
- Parity: Prescale=16, PAR_EN=1, P_DATA=0x07.
  - PAR_TYP=0 -> parity bit 1; PAR_TYP=1 -> parity bit 0.
  - Frame length 176 cycles.
  - Loopback into the receiver with the same settings -> received 0x07, no parity or stop error.
- Busy ignore: during a frame, pulse DATA_VALID with P_DATA=0xFF and change Prescale -> current frame unchanged, and no second frame follows.
- Back-to-back: hold DATA_VALID=1 with 0x55 then 0xAA.
  - Second START begins one cycle after tx_done.
  - Stop level lasts P+1 cycles.
  - Both bytes decode correctly.
- Reset mid-frame: assert rst during DATA bit 3 -> next edge TX_OUT=1, busy=0, no tx_done. A new request after reset sends a full, correct frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Transmit-side handshake for uart_tx: parallel request and frame settings in,
// registered serial line and status out.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [4:0]            Prescale;
  logic                  TX_OUT;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy, tx_done
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit; every bit lasts max(Prescale,2) clk cycles latched at accept.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_nx;
  logic [4:0]            cnt, cnt_nx;
  logic [IDX_W-1:0]      bit_idx, bit_idx_nx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [4:0]            presc_q;
  logic                  tx_nx, busy_nx, done_nx;
  logic                  accept, bit_end;

  assign accept  = (state == S_IDLE) && bus.DATA_VALID;
  assign bit_end = (cnt == presc_q - 5'd1);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx   = S_START;
          cnt_nx     = 5'd0;
          bit_idx_nx = '0;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        cnt_nx = bit_end ? 5'd0 : cnt + 5'd1;
        if (bit_end) begin
          case (state)
            S_START: begin
              state_nx   = S_DATA;
              bit_idx_nx = '0;
            end
            S_DATA: begin
              if (bit_idx == LAST_IDX) state_nx = par_en_q ? S_PARITY : S_STOP;
              else                     bit_idx_nx = bit_idx + 1'b1;
            end
            S_PARITY: state_nx = S_STOP;
            default:  state_nx = S_IDLE;
          endcase
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Outputs are a function of the next state so that, once registered, they
    // line up with the state they describe and only move on bit boundaries.
    case (state_nx)
      S_START:  tx_nx = 1'b0;
      S_DATA:   tx_nx = data_q[bit_idx_nx];
      S_PARITY: tx_nx = par_bit_q;
      default:  tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state == S_STOP) && bit_end;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 5'd0;
      bit_idx     <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      presc_q     <= 5'd0;
      bus.TX_OUT  <= 1'b1;
      bus.busy    <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bit_idx     <= bit_idx_nx;
      bus.TX_OUT  <= tx_nx;
      bus.busy    <= busy_nx;
      bus.tx_done <= done_nx;
      if (accept) begin
        data_q    <= bus.P_DATA;
        par_en_q  <= bus.PAR_EN;
        par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
        presc_q   <= (bus.Prescale < 5'd2) ? 5'd2 : bus.Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line comparison against a frame
// model built from the byte and settings, plus a mid-bit sampling decoder.
module tb_uart_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  logic line_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_p(input int pre);
    return (pre < 2) ? 2 : pre;
  endfunction

  task automatic drive_req(input logic [W-1:0] d, input bit pe, input bit pt, input int pre);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = 5'(pre);
    bus.DATA_VALID = 1'b1;
  endtask

  // Called right after the accepting edge. Checks every cycle of the frame and
  // the end-of-frame edge. mode: 0 quiet inputs, 1 random input noise,
  // 2 keep DATA_VALID high with next_d, 3 one busy-time request of 0xFF.
  task automatic check_frame(input logic [W-1:0] d, input bit pe, input bit pt,
                             input int p, input int mode, input logic [W-1:0] next_d,
                             input string tag);
    logic bits[$];
    int   len;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(((^d) ^ pt) != 0);
    bits.push_back(1'b1);
    len = bits.size() * p;

    if (mode == 2) bus.P_DATA = next_d;
    else           bus.DATA_VALID = 1'b0;

    for (int c = 0; c < len; c++) begin
      line_q.push_back(bus.TX_OUT);
      n_cmp++;
      if (bus.TX_OUT !== bits[c / p] || bus.busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s cycle %0d: tx/busy/done=%b%b%b expected %b10",
                 tag, c, bus.TX_OUT, bus.busy, bus.tx_done, bits[c / p]);
      end
      if (mode == 1) begin
        if (c < len - 1) begin
          bus.P_DATA     = W'($urandom);
          bus.Prescale   = 5'($urandom);
          bus.PAR_EN     = 1'($urandom);
          bus.PAR_TYP    = 1'($urandom);
          bus.DATA_VALID = 1'($urandom);
        end else begin
          bus.DATA_VALID = 1'b0;
        end
      end else if (mode == 3) begin
        bus.DATA_VALID = (c == 5);
        if (c == 5) begin
          bus.P_DATA   = 8'hFF;
          bus.Prescale = 5'(p + 3);
        end
      end
      tick();
    end
    line_q.push_back(bus.TX_OUT);
    n_cmp++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame_end after %0d cycles: tx/busy/done=%b%b%b expected 101",
               tag, len, bus.TX_OUT, bus.busy, bus.tx_done);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      n_cmp++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle cycle %0d: tx/busy/done=%b%b%b expected 100",
                 tag, i, bus.TX_OUT, bus.busy, bus.tx_done);
      end
    end
  endtask

  // Receiver model: sample the captured line in the middle of each bit.
  task automatic decode(input int s, input int p, input bit pe, input bit pt,
                        output logic [W-1:0] d, output bit err);
    int k;
    err = (line_q[s + p / 2] !== 1'b0);
    for (int i = 0; i < W; i++) d[i] = line_q[s + (i + 1) * p + p / 2];
    k = W + 1;
    if (pe) begin
      if (line_q[s + k * p + p / 2] !== ((^d) ^ pt)) err = 1'b1;
      k++;
    end
    if (line_q[s + k * p + p / 2] !== 1'b1) err = 1'b1;
  endtask

  task automatic check_decode(input int s, input int p, input bit pe, input bit pt,
                              input logic [W-1:0] exp_d, input string tag);
    logic [W-1:0] got;
    bit           err;
    decode(s, p, pe, pt, got, err);
    n_cmp++;
    if (got !== exp_d || err) begin
      n_err++;
      $display("FAIL %s decode: got %h err=%0b expected %h err=0", tag, got, err, exp_d);
    end
  endtask

  task automatic test_reset;
    drive_req(8'h3C, 1'b0, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset cycle %0d: tx/busy/done=%b%b%b expected 100",
                 i, bus.TX_OUT, bus.busy, bus.tx_done);
      end
    end
    bus.DATA_VALID = 1'b0;
    rst = 1'b0;
    idle_check(3, "reset_release");
  endtask

  task automatic test_no_parity;
    logic exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int   s;
    drive_req(8'hA5, 1'b0, 1'b0, 8);
    tick();
    s = line_q.size();
    check_frame(8'hA5, 1'b0, 1'b0, 8, 0, '0, "nopar_a5");
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (line_q[s + k * 8 + 4] !== exp_a5[k]) begin
        n_err++;
        $display("FAIL nopar_a5 bit %0d: got %b expected %b", k, line_q[s + k * 8 + 4], exp_a5[k]);
      end
    end
    idle_check(3, "nopar_after");
  endtask

  task automatic test_parity;
    int s;
    for (int t = 0; t < 2; t++) begin
      drive_req(8'h07, 1'b1, 1'(t), 16);
      tick();
      s = line_q.size();
      check_frame(8'h07, 1'b1, 1'(t), 16, 0, '0, "parity_07");
      n_cmp++;
      if (line_q[s + 9 * 16 + 8] !== ((t == 0) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL parity_07 typ=%0d parity bit: got %b expected %b",
                 t, line_q[s + 9 * 16 + 8], (t == 0) ? 1'b1 : 1'b0);
      end
      check_decode(s, 16, 1'b1, 1'(t), 8'h07, "parity_07");
      idle_check(2, "parity_after");
    end
  endtask

  task automatic test_busy_ignore;
    int s;
    drive_req(8'h3C, 1'b1, 1'b1, 6);
    tick();
    s = line_q.size();
    check_frame(8'h3C, 1'b1, 1'b1, 6, 3, '0, "busy_ignore");
    check_decode(s, 6, 1'b1, 1'b1, 8'h3C, "busy_ignore");
    idle_check(12, "busy_no_second");
  endtask

  task automatic test_back_to_back;
    int s1, s2, p, ones;
    p = $urandom_range(2, 6);
    drive_req(8'h55, 1'b0, 1'b0, p);
    tick();
    s1 = line_q.size();
    check_frame(8'h55, 1'b0, 1'b0, p, 2, 8'hAA, "b2b_first");
    tick();
    ones = 0;
    for (int i = line_q.size() - 1; i >= 0 && line_q[i] === 1'b1; i--) ones++;
    n_cmp++;
    if (ones != p + 1) begin
      n_err++;
      $display("FAIL b2b stop_len: got %0d cycles expected %0d", ones, p + 1);
    end
    s2 = line_q.size();
    check_frame(8'hAA, 1'b0, 1'b0, p, 0, '0, "b2b_second");
    check_decode(s1, p, 1'b0, 1'b0, 8'h55, "b2b_first");
    check_decode(s2, p, 1'b0, 1'b0, 8'hAA, "b2b_second");
    idle_check(3, "b2b_after");
  endtask

  task automatic test_min_prescale;
    for (int pre = 0; pre < 3; pre++) begin
      logic [W-1:0] d;
      int           s;
      d = W'($urandom);
      drive_req(d, 1'b1, 1'b0, pre);
      tick();
      s = line_q.size();
      check_frame(d, 1'b1, 1'b0, eff_p(pre), 0, '0, "min_prescale");
      check_decode(s, eff_p(pre), 1'b1, 1'b0, d, "min_prescale");
      idle_check(1, "min_prescale_after");
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] d;
      bit           pe, pt;
      int           pre, s;
      d   = W'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pre = $urandom_range(0, 10);
      drive_req(d, pe, pt, pre);
      tick();
      s = line_q.size();
      check_frame(d, pe, pt, eff_p(pre), 1, '0, "random");
      check_decode(s, eff_p(pre), pe, pt, d, "random");
      idle_check(2, "random_after");
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [W-1:0] d;
    int           s;
    d = W'($urandom);
    drive_req(d, 1'b0, 1'b0, 4);
    tick();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    n_cmp++;
    if (bus.TX_OUT !== d[3] || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid in_bit3: tx/busy=%b%b expected %b1", bus.TX_OUT, bus.busy, d[3]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid abort: tx/busy/done=%b%b%b expected 100",
               bus.TX_OUT, bus.busy, bus.tx_done);
    end
    idle_check(45, "rst_mid_idle");
    d = W'($urandom);
    drive_req(d, 1'b1, 1'b1, 5);
    tick();
    s = line_q.size();
    check_frame(d, 1'b1, 1'b1, 5, 0, '0, "rst_mid_new");
    check_decode(s, 5, 1'b1, 1'b1, d, "rst_mid_new");
    idle_check(2, "rst_mid_after");
  endtask

  initial begin
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 5'd8;
    test_reset();
    test_no_parity();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_min_prescale();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
